// File: rtl/systemizer_pkg.sv
// Shared types and constants for the systemizer phase sequencer.
package systemizer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        NEXT,
        ABORT
    } ctrl_state_t;

    localparam int ENG_RST_CYCLES = 2;
    localparam int RST_CNT_W      = $clog2(ENG_RST_CYCLES + 1);

    function automatic int calc_addr_w(input int l, input int k, input int n);
        return $clog2(l * k / n);
    endfunction

    function automatic int calc_blk_w(input int k, input int n);
        return $clog2(k / n + 1);
    endfunction

endpackage

// File: rtl/systemizer_mem_mux.sv
// Host/engine memory port arbitration; flags host accesses attempted while busy.
module systemizer_mem_mux
    import systemizer_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) (
    input  logic              busy,
    input  logic              host_rd_en,
    input  logic [ADDR_W-1:0] host_rd_addr,
    output logic [DATA_W-1:0] host_dout,
    input  logic              host_wr_en,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_din,
    output logic              eng_rd_en,
    output logic [ADDR_W-1:0] eng_rd_addr,
    input  logic [DATA_W-1:0] eng_dout,
    output logic              eng_wr_en,
    output logic [ADDR_W-1:0] eng_wr_addr,
    output logic [DATA_W-1:0] eng_din,
    output logic              acc_err_set
);

    always_comb begin
        eng_rd_en   = host_rd_en & ~busy;
        eng_rd_addr = host_rd_addr;
        eng_wr_en   = host_wr_en & ~busy;
        eng_wr_addr = host_wr_addr;
        eng_din     = host_din;
        host_dout   = eng_dout;
        acc_err_set = busy & (host_rd_en | host_wr_en);
    end

endmodule

// File: rtl/systemizer_phase_ctrl.sv
// Phase sequencer for the GF(2^M) systemizer engine.
// Optional SYSTEMIZER_CYCLE_COUNT_EN adds a saturating busy-cycle counter output.
module systemizer_phase_ctrl
    import systemizer_pkg::*;
#(
    parameter int N          = 4,
    parameter int M          = 1,
    parameter int L          = 8,
    parameter int K          = 16,
    parameter int NUM_PHASES = L / N,
    parameter int ADDR_W     = calc_addr_w(L, K, N),
    parameter int BLK_W      = calc_blk_w(K, N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              acc_err,
    output logic [BLK_W-1:0]  phase_idx,
    input  logic              host_rd_en,
    input  logic [ADDR_W-1:0] host_rd_addr,
    output logic [N*M-1:0]    host_dout,
    input  logic              host_wr_en,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [N*M-1:0]    host_din,
    output logic              eng_rst,
    output logic              eng_start,
    output logic              eng_last_phase,
    output logic [BLK_W-1:0]  eng_start_block,
    input  logic              eng_done,
    input  logic              eng_fail,
    output logic              eng_rd_en,
    output logic [ADDR_W-1:0] eng_rd_addr,
    input  logic [N*M-1:0]    eng_dout,
    output logic              eng_wr_en,
    output logic [ADDR_W-1:0] eng_wr_addr,
    output logic [N*M-1:0]    eng_din
`ifdef SYSTEMIZER_CYCLE_COUNT_EN
    ,
    output logic [31:0]       cycle_cnt
`endif
);

    if (NUM_PHASES > K / N || NUM_PHASES < 1) begin : g_bad_phases
        $error("systemizer_phase_ctrl: NUM_PHASES must be in 1..K/N");
    end

    ctrl_state_t          state_q, state_d;
    logic [BLK_W-1:0]     phase_idx_q, phase_idx_d;
    logic                 fail_q, fail_d;
    logic                 acc_err_q, acc_err_d;
    logic                 done_q, done_d;
    logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic                 acc_err_set;
    logic                 last_phase;

    assign last_phase = (phase_idx_q == BLK_W'(NUM_PHASES - 1));

    always_comb begin
        state_d     = state_q;
        phase_idx_d = phase_idx_q;
        fail_d      = fail_q;
        acc_err_d   = acc_err_q | acc_err_set;
        done_d      = 1'b0;
        rst_cnt_d   = (rst_cnt_q != '0) ? rst_cnt_q - RST_CNT_W'(1) : '0;
        unique case (state_q)
            IDLE: begin
                if (run) begin
                    fail_d      = 1'b0;
                    acc_err_d   = 1'b0;
                    phase_idx_d = '0;
                    state_d     = START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (eng_fail) begin
                    fail_d  = 1'b1;
                    state_d = IDLE;
                end else if (eng_done) begin
                    if (last_phase) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                phase_idx_d = phase_idx_q + BLK_W'(1);
                state_d     = START;
            end
            ABORT: begin
                if (rst_cnt_q <= RST_CNT_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over any engine event landing in the same cycle.
        if (abort && (state_q == START || state_q == WAIT || state_q == NEXT)) begin
            state_d     = ABORT;
            rst_cnt_d   = RST_CNT_W'(ENG_RST_CYCLES);
            done_d      = 1'b0;
            fail_d      = fail_q;
            phase_idx_d = phase_idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            phase_idx_q <= '0;
            fail_q      <= 1'b0;
            acc_err_q   <= 1'b0;
            done_q      <= 1'b0;
            rst_cnt_q   <= RST_CNT_W'(ENG_RST_CYCLES);
        end else begin
            state_q     <= state_d;
            phase_idx_q <= phase_idx_d;
            fail_q      <= fail_d;
            acc_err_q   <= acc_err_d;
            done_q      <= done_d;
            rst_cnt_q   <= rst_cnt_d;
        end
    end

    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign fail            = fail_q;
    assign acc_err         = acc_err_q;
    assign phase_idx       = phase_idx_q;
    assign eng_rst         = (rst_cnt_q != '0);
    assign eng_start       = (state_q == START);
    assign eng_start_block = phase_idx_q;
    assign eng_last_phase  = last_phase && (state_q == START || state_q == WAIT);

    systemizer_mem_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (N * M)
    ) u_mem_mux (
        .busy         (busy),
        .host_rd_en   (host_rd_en),
        .host_rd_addr (host_rd_addr),
        .host_dout    (host_dout),
        .host_wr_en   (host_wr_en),
        .host_wr_addr (host_wr_addr),
        .host_din     (host_din),
        .eng_rd_en    (eng_rd_en),
        .eng_rd_addr  (eng_rd_addr),
        .eng_dout     (eng_dout),
        .eng_wr_en    (eng_wr_en),
        .eng_wr_addr  (eng_wr_addr),
        .eng_din      (eng_din),
        .acc_err_set  (acc_err_set)
    );

`ifdef SYSTEMIZER_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == IDLE && run) begin
            cyc_d = '0;
        end else if (busy && cyc_q != '1) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cyc_q <= '0;
        else      cyc_q <= cyc_d;
    end

    assign cycle_cnt = cyc_q;
`endif

endmodule
